iterative_shifter: RTL and testbench

- Multi-cycle shift unit for the R-type datapath's shift instructions: sll, srl, sra.
- Accepts an operand and a shift amount, then applies one 1-bit shift per clock until the count is exhausted.
- Sits between the register-file read/ALU-control stage and the writeback mux.
- Left shifts are built on the existing one-bit shift_left mux stage; right shifts use a matching one-bit right stage.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_left.sv | 20 ++
 rtl/shift_right_1.sv | 22 ++
 rtl/iterative_shifter.sv | 107 ++++++++++
 tb/tb_iterative_shifter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative shift unit: operation encodings,
// FSM state encodings and default operand/shift-amount widths.
package shift_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned SHW_DEF   = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_FINISH = 2'b10
    } state_t;

endpackage

// File: rtl/shift_left.sv
// One-bit left shift mux stage.
// Ports:
//   d - operand
//   S - shift enable (1: shift left by one with zero fill, 0: pass through)
//   y - stage output
module shift_left #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d,
    input  logic             S,
    output logic [WIDTH-1:0] y
);

    assign y[0] = d[0] & ~S;

    for (genvar i = 1; i < WIDTH; i++) begin : g_bit
        assign y[i] = (S & d[i-1]) | (~S & d[i]);
    end

endmodule

// File: rtl/shift_right_1.sv
// One-bit right shift mux stage with a selectable fill bit.
// Ports:
//   d    - operand
//   fill - bit shifted into the MSB (0 for logical, sign bit for arithmetic)
//   S    - shift enable (1: shift right by one, 0: pass through)
//   y    - stage output
module shift_right_1 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] d,
    input  logic             fill,
    input  logic             S,
    output logic [WIDTH-1:0] y
);

    assign y[WIDTH-1] = (S & fill) | (~S & d[WIDTH-1]);

    for (genvar i = 0; i < WIDTH - 1; i++) begin : g_bit
        assign y[i] = (S & d[i+1]) | (~S & d[i]);
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift unit for sll/srl/sra: applies one 1-bit shift per clock
// until the latched shift amount is exhausted.
// Ports:
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request, sampled only in IDLE
//   op      - 00 sll, 01 srl, 10 sra, 11 illegal
//   data_in - operand
//   shamt   - shift amount
//   busy    - high while in SHIFT
//   done    - one-cycle pulse, result valid while high
//   result  - shifted value, held until the next completion
//   err     - pulses with done for an illegal op
module iterative_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    state_t           state, state_next;
    logic [WIDTH-1:0] work, work_next;
    logic [SHW-1:0]   count, count_next;
    op_t              op_q, op_next;
    logic [WIDTH-1:0] left_y, right_y;
    logic             fill;

    assign fill = (op_q == OP_SRA) ? work[WIDTH-1] : 1'b0;

    shift_left #(.WIDTH(WIDTH)) u_left (
        .d (work),
        .S (1'b1),
        .y (left_y)
    );

    shift_right_1 #(.WIDTH(WIDTH)) u_right (
        .d    (work),
        .fill (fill),
        .S    (1'b1),
        .y    (right_y)
    );

    always_comb begin
        state_next = state;
        work_next  = work;
        count_next = count;
        op_next    = op_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    work_next  = data_in;
                    count_next = shamt;
                    op_next    = op_t'(op);
                    if (op_t'(op) == OP_ILL || shamt == '0) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_next  = (op_q == OP_SLL) ? left_y : right_y;
                count_next = count - SHW'(1);
                if (count == SHW'(1)) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // result is captured on entry to FINISH so it is already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            work   <= '0;
            count  <= '0;
            op_q   <= OP_SLL;
            result <= '0;
        end else begin
            state <= state_next;
            work  <= work_next;
            count <= count_next;
            op_q  <= op_next;
            if (state_next == ST_FINISH) begin
                result <= work_next;
            end
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_FINISH);
    assign err  = (state == ST_FINISH) && (op_q == OP_ILL);

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_in = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, err;
    logic [31:0] result;

    int total = 0;
    int bad = 0;

    iterative_shifter #(.WIDTH(32), .SHW(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Present a request, let the next rising edge accept it, then drop start.
    // Returns 1 ns after the acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        op = o; data_in = d; shamt = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        data_in = 32'hA5A5_A5A5;
        shamt = 5'd7;
        op = 2'b01;
    endtask

    // Called just after the acceptance edge; lat = edges from acceptance to done.
    task automatic wait_done(output int lat, output int busy_cycles);
        lat = 1;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        total++;
        if ({busy, done, err} !== 3'b000 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b result=%h required 0 0 0 00000000",
                     busy, done, err, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        issue(2'b00, 32'h0000_0001, 5'd20);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err} !== 3'b000 || result !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b result=%h required 0 0 0 00000000",
                     busy, done, err, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL reset_mid_no_done: active cycles=%0d required 0", seen);
        end
        issue(2'b00, 32'h0000_0001, 5'd3);
        wait_done(lat, bc);
        total++;
        if (lat != 4 || result !== 32'h0000_0008) begin
            bad++;
            $display("FAIL reset_mid_restart: lat=%0d result=%h required 4 00000008", lat, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sll;
        int lat, bc;
        issue(2'b00, 32'h0000_0001, 5'd31);
        wait_done(lat, bc);
        total++;
        if (lat != 32 || bc != 31) begin
            bad++;
            $display("FAIL sll31_timing: lat=%0d busy=%0d required 32 31", lat, bc);
        end
        total++;
        if (result !== 32'h8000_0000 || err !== 1'b0) begin
            bad++;
            $display("FAIL sll31_result: result=%h err=%b required 80000000 0", result, err);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || result !== 32'h8000_0000) begin
            bad++;
            $display("FAIL sll31_hold: done=%b result=%h required 0 80000000", done, result);
        end
    endtask

    task automatic test_srl_sra;
        int lat, bc;
        issue(2'b01, 32'hF000_0000, 5'd4);
        wait_done(lat, bc);
        total++;
        if (lat != 5 || result !== 32'h0F00_0000) begin
            bad++;
            $display("FAIL srl4: lat=%0d result=%h required 5 0F000000", lat, result);
        end
        @(posedge clk); #1;
        issue(2'b10, 32'hF000_0000, 5'd4);
        wait_done(lat, bc);
        total++;
        if (lat != 5 || result !== 32'hFF00_0000) begin
            bad++;
            $display("FAIL sra4: lat=%0d result=%h required 5 FF000000", lat, result);
        end
        @(posedge clk); #1;
        issue(2'b10, 32'h8000_0000, 5'd31);
        wait_done(lat, bc);
        total++;
        if (result !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL sra31_neg: result=%h required FFFFFFFF", result);
        end
        @(posedge clk); #1;
        issue(2'b01, 32'h8000_0000, 5'd31);
        wait_done(lat, bc);
        total++;
        if (result !== 32'h0000_0001) begin
            bad++;
            $display("FAIL srl31_neg: result=%h required 00000001", result);
        end
        @(posedge clk); #1;
        issue(2'b10, 32'h4000_0000, 5'd31);
        wait_done(lat, bc);
        total++;
        if (result !== 32'h0000_0000) begin
            bad++;
            $display("FAIL sra31_pos: result=%h required 00000000", result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_illegal;
        int lat, bc;
        issue(2'b10, 32'h1234_5678, 5'd0);
        wait_done(lat, bc);
        total++;
        if (lat != 1 || bc != 0 || result !== 32'h1234_5678 || err !== 1'b0) begin
            bad++;
            $display("FAIL zero_shift: lat=%0d busy=%0d result=%h err=%b required 1 0 12345678 0",
                     lat, bc, result, err);
        end
        @(posedge clk); #1;
        issue(2'b11, 32'hDEAD_BEEF, 5'd5);
        wait_done(lat, bc);
        total++;
        if (lat != 1 || err !== 1'b1 || result !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL illegal_op: lat=%0d err=%b result=%h required 1 1 DEADBEEF",
                     lat, err, result);
        end
        @(posedge clk); #1;
        total++;
        if (err !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pulse: err=%b done=%b required 0 0", err, done);
        end
    endtask

    task automatic test_busy_protect;
        int dones, done_at;
        issue(2'b01, 32'hFFFF_FFFF, 5'd8);
        dones = 0;
        done_at = 0;
        for (int c = 1; c <= 14; c++) begin
            if (done) begin dones++; done_at = c; end
            if (c == 3 || c == 9) begin
                start = 1'b1; data_in = 32'h0; shamt = 5'd2; op = 2'b00;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if (dones != 1 || done_at != 9) begin
            bad++;
            $display("FAIL busy_protect_done: count=%0d at=%0d required 1 9", dones, done_at);
        end
        total++;
        if (result !== 32'h00FF_FFFF) begin
            bad++;
            $display("FAIL busy_protect_result: result=%h required 00FFFFFF", result);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        issue(2'b00, 32'h0000_0001, 5'd2);
        wait_done(lat, bc);
        total++;
        if (lat != 3 || result !== 32'h0000_0004) begin
            bad++;
            $display("FAIL b2b_first: lat=%0d result=%h required 3 00000004", lat, result);
        end
        @(posedge clk); #1;
        issue(2'b00, 32'h0000_0003, 5'd1);
        total++;
        if (result !== 32'h0000_0004 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_hold: result=%h busy=%b required 00000004 1", result, busy);
        end
        wait_done(lat, bc);
        total++;
        if (lat != 2 || result !== 32'h0000_0006) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d result=%h required 2 00000006", lat, result);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_reset_mid;
        test_sll;
        test_srl_sra;
        test_zero_illegal;
        test_busy_protect;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
